// File: rtl/mem_access_unit.sv
// Load/store front end: turns one RV32 load/store into word-wide memory
// accesses, using read-modify-write for SB/SH, and returns one response.
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic        accept;
    logic [2:0]  size;
    logic [32:0] end_addr;
    logic        range_err;
    logic        align_err;
    logic        f3_err;
    logic        req_err;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        size = 3'd4;
        case (req_funct3[1:0])
            2'd0:    size = 3'd1;
            2'd1:    size = 3'd2;
            default: size = 3'd4;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign end_addr  = {1'b0, req_addr} + {30'd0, size};
    assign range_err = end_addr > 33'(MEM_BYTES);
    assign align_err = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    assign f3_err    = req_we ? (req_funct3 > 3'd2)
                              : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                                 (req_funct3 == 3'd7));
    assign req_err   = range_err || align_err || f3_err;

    assign rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = mem_rdata;
        unique case (1'b1)
            f3_q == 3'd0: ext_data = {{24{rd_byte[7]}}, rd_byte};
            f3_q == 3'd1: ext_data = {{16{rd_half[15]}}, rd_half};
            f3_q == 3'd4: ext_data = {24'd0, rd_byte};
            f3_q == 3'd5: ext_data = {16'd0, rd_half};
            default:      ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_we && (req_funct3[1:0] == 2'd2))
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = CAP;
            CAP:     state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // rsp_rdata/rsp_err only change on the way into RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_wdata;
                f3_q   <= req_funct3;
                we_q   <= req_we;
                if (req_err) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (state == CAP) begin
                if (we_q) begin
                    data_q <= merged;
                end else begin
                    rsp_rdata <= ext_data;
                    rsp_err   <= 1'b0;
                end
            end
            if (state == WR) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_re    = (state == RD);
    assign mem_we    = (state == WR);
    assign mem_addr  = ((state == RD) || (state == CAP) || (state == WR)) ?
                       {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = (state == WR) ? data_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 1 KiB synchronous word memory.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;
    int          re_cnt;
    int          we_cnt;
    int          overlap_cnt;

    int tests;
    int fails;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= mem[mem_addr[9:2]];
        if (mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
        if (tb_we)
            mem[tb_idx] <= tb_data;
        re_cnt      <= re_cnt + (mem_re ? 1 : 0);
        we_cnt      <= we_cnt + (mem_we ? 1 : 0);
        overlap_cnt <= overlap_cnt + ((mem_re && mem_we) ? 1 : 0);
    end

    initial begin
        re_cnt      = 0;
        we_cnt      = 0;
        overlap_cnt = 0;
        mem_rdata   = '0;
        for (int i = 0; i < 256; i++)
            mem[i] = '0;
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_idx  = a[9:2];
        tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic er, output int dre, output int dwe);
        int re0;
        int we0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        re0 = re_cnt;
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rd  = 'x;
        er  = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
        end
        dre = re_cnt - re0;
        dwe = we_cnt - we0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        tests++;
        if ({rsp_valid, rsp_err, mem_re, mem_we} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes got %b want 0000",
                     {rsp_valid, rsp_err, mem_re, mem_we});
        end
        tests++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            fails++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h want 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loads;
        logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] ad  [5] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF8001,
                                 32'h0000F0FF, 32'h8001F0FF};
        int lat;
        int dre;
        int dwe;
        logic [31:0] rd;
        logic er;
        poke(32'h10, 32'h8001F0FF);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0, lat, rd, er, dre, dwe);
            tests++;
            if ({rd, er} !== {exp[i], 1'b0}) begin
                fails++;
                $display("FAIL load%0d data got %h err %b want %h err 0",
                         i, rd, er, exp[i]);
            end
            tests++;
            if (lat !== 3 || dre !== 1 || dwe !== 0) begin
                fails++;
                $display("FAIL load%0d timing lat=%0d re=%0d we=%0d want 3/1/0",
                         i, lat, dre, dwe);
            end
        end
    endtask

    task automatic test_stores;
        int lat;
        int dre;
        int dwe;
        logic [31:0] rd;
        logic er;
        poke(32'h10, 32'h11223344);
        do_req(1'b1, 3'd0, 32'h11, 32'h000000AB, lat, rd, er, dre, dwe);
        tests++;
        if (mem[4] !== 32'h1122AB44) begin
            fails++;
            $display("FAIL sb_word got %h want 1122AB44", mem[4]);
        end
        tests++;
        if (lat !== 4 || dre !== 1 || dwe !== 1 || er !== 1'b0 || rd !== 32'd0) begin
            fails++;
            $display("FAIL sb_rsp lat=%0d re=%0d we=%0d err=%b rd=%h want 4/1/1/0/0",
                     lat, dre, dwe, er, rd);
        end
        poke(32'h10, 32'h11223344);
        do_req(1'b1, 3'd1, 32'h12, 32'h5555BEEF, lat, rd, er, dre, dwe);
        tests++;
        if (mem[4] !== 32'hBEEF3344 || lat !== 4 || dre !== 1 || dwe !== 1) begin
            fails++;
            $display("FAIL sh_word got %h lat=%0d re=%0d we=%0d want BEEF3344/4/1/1",
                     mem[4], lat, dre, dwe);
        end
        do_req(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, lat, rd, er, dre, dwe);
        tests++;
        if (mem[8] !== 32'hDEADBEEF || lat !== 2 || dre !== 0 || dwe !== 1 ||
            er !== 1'b0) begin
            fails++;
            $display("FAIL sw_word got %h lat=%0d re=%0d we=%0d err=%b want DEADBEEF/2/0/1/0",
                     mem[8], lat, dre, dwe, er);
        end
    endtask

    task automatic test_errors;
        logic        we [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3 [6] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd0, 3'd3};
        logic [31:0] ad [6] = '{32'h22, 32'h13, 32'h10, 32'h3FE, 32'h400, 32'h10};
        int lat;
        int dre;
        int dwe;
        logic [31:0] rd;
        logic er;
        for (int i = 0; i < 6; i++) begin
            do_req(we[i], f3[i], ad[i], 32'hFFFFFFFF, lat, rd, er, dre, dwe);
            tests++;
            if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || dre !== 0 || dwe !== 0) begin
                fails++;
                $display("FAIL err%0d err=%b rd=%h lat=%0d re=%0d we=%0d want 1/0/1/0/0",
                         i, er, rd, lat, dre, dwe);
            end
        end
        poke(32'h3FC, 32'hA5A5C3C3);
        do_req(1'b0, 3'd2, 32'h3FC, 32'h0, lat, rd, er, dre, dwe);
        tests++;
        if (er !== 1'b0 || rd !== 32'hA5A5C3C3 || lat !== 3) begin
            fails++;
            $display("FAIL lw_top err=%b rd=%h lat=%0d want 0/A5A5C3C3/3",
                     er, rd, lat);
        end
    endtask

    task automatic test_reset_mid;
        int we0;
        int lat;
        int dre;
        int dwe;
        logic [31:0] rd;
        logic er;
        poke(32'h10, 32'h11223344);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000099;
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({rsp_valid, rsp_err, mem_re, mem_we} !== 4'b0000 ||
            {rsp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            fails++;
            $display("FAIL mid_reset_outs v=%b e=%b re=%b we=%b rd=%h a=%h wd=%h want 0",
                     rsp_valid, rsp_err, mem_re, mem_we, rsp_rdata, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || we_cnt !== we0 || mem[4] !== 32'h11223344) begin
            fails++;
            $display("FAIL mid_reset_after ready=%b writes=%0d word=%h want 1/0/11223344",
                     req_ready, we_cnt - we0, mem[4]);
        end
        do_req(1'b0, 3'd4, 32'h10, 32'h0, lat, rd, er, dre, dwe);
        tests++;
        if (rd !== 32'h00000044 || lat !== 3) begin
            fails++;
            $display("FAIL mid_reset_resume rd=%h lat=%0d want 00000044/3", rd, lat);
        end
    endtask

    task automatic test_back_to_back;
        int busy_ready;
        logic [31:0] first_addr;
        logic [31:0] first_rd;
        logic        first_rsp;
        logic        idle_ready;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        wr_seen;
        busy_ready = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        @(posedge clk);
        #1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        busy_ready += req_ready ? 1 : 0;
        first_addr = mem_addr;
        @(negedge clk);
        busy_ready += req_ready ? 1 : 0;
        @(negedge clk);
        busy_ready += req_ready ? 1 : 0;
        first_rsp = rsp_valid;
        first_rd  = rsp_rdata;
        @(negedge clk);
        idle_ready = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        wr_seen = mem_we;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        @(negedge clk);
        tests++;
        if (first_addr !== 32'h10 || first_rsp !== 1'b1 || first_rd !== 32'h11223344) begin
            fails++;
            $display("FAIL b2b_first addr=%h rsp=%b rd=%h want 10/1/11223344",
                     first_addr, first_rsp, first_rd);
        end
        tests++;
        if (busy_ready !== 0 || idle_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready busy=%0d idle=%b want 0/1", busy_ready, idle_ready);
        end
        tests++;
        if (wr_seen !== 1'b1 || wr_addr !== 32'h20 || wr_data !== 32'hCAFEF00D ||
            rsp_valid !== 1'b1 || mem[8] !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL b2b_second we=%b a=%h d=%h rsp=%b word=%h want 1/20/CAFEF00D/1/CAFEF00D",
                     wr_seen, wr_addr, wr_data, rsp_valid, mem[8]);
        end
        tests++;
        if (overlap_cnt !== 0) begin
            fails++;
            $display("FAIL strobe_overlap got %0d want 0", overlap_cnt);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        tb_we      = 1'b0;
        tb_idx     = '0;
        tb_data    = '0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
